// File: rtl/srff_driver_if.sv
// Request, excitation and feedback signals between a requester, srff_driver and the SR flip-flop it drives.
interface srff_driver_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic s;
  logic r;
  logic q_fb;
  logic done;
  logic err;

  modport master (
    output in_valid, in_bit, q_fb,
    input  in_ready, s, r, done, err
  );

  modport slave (
    input  in_valid, in_bit, q_fb,
    output in_ready, s, r, done, err
  );
endinterface

// File: rtl/srff_driver.sv
// Drives an SR flip-flop to a requested value: done 3 cycles after acceptance (1 on a hold); in_ready only in IDLE.
// Optional SRFF_DRV_RETRY_EN: the first timeout re-drives once before flagging err.
module srff_driver #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  srff_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       target, target_nxt;
  logic       s_q, s_nxt;
  logic       r_q, r_nxt;
  logic       done_q, done_nxt;
  logic       err_q, err_nxt;
  logic [7:0] cnt, cnt_nxt;
`ifdef SRFF_DRV_RETRY_EN
  logic       retried, retried_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      target  <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
`ifdef SRFF_DRV_RETRY_EN
      retried <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      target  <= target_nxt;
      s_q     <= s_nxt;
      r_q     <= r_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      cnt     <= cnt_nxt;
`ifdef SRFF_DRV_RETRY_EN
      retried <= retried_nxt;
`endif
    end
  end

  // s/r are only ever loaded from a bit and its complement, so both-high cannot occur.
  always_comb begin
    state_nxt   = state;
    target_nxt  = target;
    s_nxt       = 1'b0;
    r_nxt       = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    cnt_nxt     = cnt;
`ifdef SRFF_DRV_RETRY_EN
    retried_nxt = retried;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          target_nxt  = bus.in_bit;
          cnt_nxt     = '0;
`ifdef SRFF_DRV_RETRY_EN
          retried_nxt = 1'b0;
`endif
          if (bus.in_bit == bus.q_fb) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = DRIVE;
            s_nxt     = bus.in_bit;
            r_nxt     = ~bus.in_bit;
          end
        end
      end
      DRIVE: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        // A match wins over a timeout on the same edge.
        if (bus.q_fb == target) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (cnt == LAST) begin
`ifdef SRFF_DRV_RETRY_EN
          if (!retried) begin
            state_nxt   = DRIVE;
            s_nxt       = target;
            r_nxt       = ~target;
            cnt_nxt     = '0;
            retried_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
`else
          state_nxt = IDLE;
          err_nxt   = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
